osc_multi: RTL and testbench

Parametrised multi-waveform oscillator; successor to the single saw/square counter oscillator in the oscillator library. A phase accumulator of COUNTER_WIDTH_P bits advances by a programmable increment per clock. The accumulator drives a signed OSC_WIDTH_P-bit output in one of four modes: square with programmable duty, rising saw, falling saw, or triangle. Configuration is double-buffered and applied only at period boundaries, so every period is glitch-free. Feeds the mixer/LFO stages and a period tick for downstream sync.

---
 rtl/osc_multi.sv | 115 +++++++++++
 tb/tb_osc_multi.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/osc_multi.sv
// Multi-waveform phase-accumulator oscillator (square / saw up / saw down / triangle).
// Configuration is shadowed and only reloaded at a phase wrap so each period is glitch-free.
module osc_multi #(
  parameter int OSC_WIDTH_P     = 24,
  parameter int COUNTER_WIDTH_P = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cr_enable,
  input  logic [1:0]                    cr_waveform,
  input  logic [COUNTER_WIDTH_P-1:0]    cr_increment,
  input  logic [COUNTER_WIDTH_P-1:0]    cr_duty_cycle,
  output logic signed [OSC_WIDTH_P-1:0] osc_out,
  output logic                          osc_period_tick
);

  localparam int N = COUNTER_WIDTH_P;
  localparam int W = OSC_WIDTH_P;
  localparam logic [W-1:0] S = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [N-1:0]          phase_q, phase_d;
  logic [N-1:0]          inc_q, inc_d;
  logic [N-1:0]          duty_q, duty_d;
  logic [1:0]            wave_q, wave_d;
  logic signed [W-1:0]   osc_q, osc_d;
  logic                  tick_q, tick_d;
  logic [N:0]            sum;
  logic                  reload;

  // Offset-binary phase slices are flipped into two's complement by toggling the MSB.
  function automatic logic signed [W-1:0] wave_map(input logic [N-1:0] p,
                                                   input logic [1:0]   w,
                                                   input logic [N-1:0] duty);
    logic [W-1:0] t;
    logic [W-1:0] f;
    logic [W-1:0] r;
    t = p[N-1 -: W];
    f = p[N-2 -: W];
    case (w)
      2'd0:    r = (p < duty) ? ~S : S;
      2'd1:    r = t ^ S;
      2'd2:    r = ~(t ^ S);
      default: r = p[N-1] ? ~(f ^ S) : (f ^ S);
    endcase
    return $signed(r);
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    inc_d   = inc_q;
    duty_d  = duty_q;
    wave_d  = wave_q;
    osc_d   = osc_q;
    tick_d  = 1'b0;
    sum     = '0;
    reload  = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        osc_d   = '0;
        if (cr_enable) begin
          reload  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        if (!cr_enable) begin
          state_d = IDLE;
          phase_d = '0;
          osc_d   = '0;
        end else begin
          sum     = {1'b0, phase_q} + {1'b0, inc_q};
          phase_d = sum[N-1:0];
          tick_d  = sum[N];
          osc_d   = wave_map(phase_q, wave_q, duty_q);
          // A zero step never wraps, so reload every cycle to let a stalled oscillator restart.
          reload  = sum[N] || (inc_q == '0);
        end
      end
    endcase
    if (reload) begin
      inc_d  = cr_increment;
      duty_d = cr_duty_cycle;
      wave_d = cr_waveform;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      inc_q   <= '0;
      duty_q  <= '0;
      wave_q  <= '0;
      osc_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
      duty_q  <= duty_d;
      wave_q  <= wave_d;
      osc_q   <= osc_d;
      tick_q  <= tick_d;
    end
  end

  assign osc_out         = osc_q;
  assign osc_period_tick = tick_q;

endmodule

// File: tb/tb_osc_multi.sv
// Bench for osc_multi at COUNTER_WIDTH_P=8, OSC_WIDTH_P=4: arithmetic reference model
// checked every cycle, plus directed sequences with hand-written expected samples.
module tb_osc_multi;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [1:0]        wave;
  logic [7:0]        inc;
  logic [7:0]        duty;
  logic signed [3:0] osc_out;
  logic              osc_period_tick;

  int checks   = 0;
  int failures = 0;

  osc_multi #(.OSC_WIDTH_P(4), .COUNTER_WIDTH_P(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cr_enable      (en),
    .cr_waveform    (wave),
    .cr_increment   (inc),
    .cr_duty_cycle  (duty),
    .osc_out        (osc_out),
    .osc_period_tick(osc_period_tick)
  );

  always #5 clk = ~clk;

  // Reference model: phase as an integer 0..255, samples as signed integers.
  int m_valid = 0;
  int m_run, m_p, m_inc, m_duty, m_wave, m_out, m_tick;

  function automatic int wave_ref(input int p, input int w, input int d);
    int t;
    int f;
    t = p / 16;
    f = (p % 128) / 8;
    case (w)
      0:       return (p < d) ? 7 : -8;
      1:       return t - 8;
      2:       return 7 - t;
      default: return (p < 128) ? (f - 8) : (7 - f);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1; m_run <= 0; m_p <= 0; m_inc <= 0; m_duty <= 0;
      m_wave <= 0; m_out <= 0; m_tick <= 0;
    end else if (m_run == 0) begin
      m_p <= 0; m_out <= 0; m_tick <= 0;
      if (en) begin
        m_run <= 1; m_inc <= int'(inc); m_duty <= int'(duty); m_wave <= int'(wave);
      end
    end else if (!en) begin
      m_run <= 0; m_p <= 0; m_out <= 0; m_tick <= 0;
    end else begin
      m_out  <= wave_ref(m_p, m_wave, m_duty);
      m_tick <= (m_p + m_inc >= 256) ? 1 : 0;
      m_p    <= (m_p + m_inc) % 256;
      if (m_p + m_inc >= 256 || m_inc == 0) begin
        m_inc <= int'(inc); m_duty <= int'(duty); m_wave <= int'(wave);
      end
    end
  end

  logic [3:0] saw_up [16] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF,
                              4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
  logic [3:0] saw_dn [16] = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0,
                              4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
  logic [3:0] sq40   [16] = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h8, 4'h8, 4'h8, 4'h8,
                              4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
  logic [3:0] tri_s  [16] = '{4'h8, 4'hA, 4'hC, 4'hE, 4'h0, 4'h2, 4'h4, 4'h6,
                              4'h7, 4'h5, 4'h3, 4'h1, 4'hF, 4'hD, 4'hB, 4'h9};
  logic [3:0] sq_mid [8]  = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h8, 4'h8, 4'h8, 4'h8};
  logic [3:0] zinc   [5]  = '{4'h8, 4'h8, 4'hC, 4'h0, 4'h4};

  // One clock: compare against the model (and optionally a literal) on the falling edge.
  task automatic cyc(input bit lit, input logic [3:0] lo, input string nm);
    logic [3:0] exp4;
    @(negedge clk);
    if (m_valid != 0) begin
      exp4 = 4'(m_out);
      checks++;
      if (osc_out !== exp4) begin
        failures++;
        $display("FAIL model_out %s: got %h want %h", nm, osc_out, exp4);
      end
      checks++;
      if (osc_period_tick !== m_tick[0]) begin
        failures++;
        $display("FAIL model_tick %s: got %b want %b", nm, osc_period_tick, m_tick[0]);
      end
    end
    if (lit) begin
      checks++;
      if (osc_out !== lo) begin
        failures++;
        $display("FAIL lit_out %s: got %h want %h", nm, osc_out, lo);
      end
    end
  endtask

  task automatic tick_lit(input bit e, input string nm);
    checks++;
    if (osc_period_tick !== e) begin
      failures++;
      $display("FAIL lit_tick %s: got %b want %b", nm, osc_period_tick, e);
    end
  endtask

  task automatic restart(input logic [1:0] w, input logic [7:0] i, input logic [7:0] d);
    en = 1'b0;
    cyc(1'b1, 4'h0, "restart_off");
    tick_lit(1'b0, "restart_off");
    wave = w; inc = i; duty = d; en = 1'b1;
    cyc(1'b1, 4'h0, "restart_load");
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; wave = 2'd0; inc = 8'd0; duty = 8'd0;
    cyc(1'b1, 4'h0, "reset");
    tick_lit(1'b0, "reset");
    cyc(1'b1, 4'h0, "reset2");
    rst_n = 1'b1;
    cyc(1'b1, 4'h0, "idle");

    // Saw up, then a saw-down request mid-period that waits for the wrap.
    wave = 2'd1; inc = 8'd16; en = 1'b1;
    cyc(1'b1, 4'h0, "sawup_load");
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, saw_up[i], "sawup"); tick_lit(i == 15, "sawup");
    end
    wave = 2'd2;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, saw_up[i], "sawup_pending"); tick_lit(i == 15, "sawup_pending");
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, saw_dn[i], "sawdn"); tick_lit(i == 15, "sawdn");
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, saw_dn[i], "sawdn2");

    // Reset mid-period.
    rst_n = 1'b0;
    cyc(1'b1, 4'h0, "rst_mid"); tick_lit(1'b0, "rst_mid");
    rst_n = 1'b1; en = 1'b0;
    cyc(1'b1, 4'h0, "rst_hold1");
    cyc(1'b1, 4'h0, "rst_hold2");

    // Square: duty 0x40, then duty 0 applied at the following wrap.
    restart(2'd0, 8'd16, 8'h40);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, sq40[i], "sq40"); tick_lit(i == 15, "sq40");
    end
    duty = 8'h00;
    for (int i = 0; i < 16; i++) cyc(1'b1, sq40[i], "sq40_pending");
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 4'h8, "sq00"); tick_lit(i == 15, "sq00");
    end

    // Duty 0xFF with step 0x11 visits P=0xFF on the 16th sample.
    restart(2'd0, 8'h11, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, (i == 15) ? 4'h8 : 4'h7, "sqff"); tick_lit(i == 15, "sqff");
    end

    restart(2'd3, 8'd16, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, tri_s[i], "tri"); tick_lit(i == 15, "tri");
    end

    // Mid-period change at P=0x50: saw finishes its period, then 8-cycle square.
    restart(2'd1, 8'd16, 8'h80);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, saw_up[i], "mid_saw"); tick_lit(i == 15, "mid_saw");
      if (i == 4) begin
        inc = 8'd32; wave = 2'd0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, sq_mid[i], "mid_sq"); tick_lit(i == 7, "mid_sq");
    end

    // Zero increment stalls at P=0, then picks up a new step.
    restart(2'd1, 8'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'h8, "zero_inc"); tick_lit(1'b0, "zero_inc");
    end
    inc = 8'd64;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, zinc[i], "inc64"); tick_lit(i == 4, "inc64");
    end
    en = 1'b0;
    cyc(1'b1, 4'h0, "disable"); tick_lit(1'b0, "disable");
    cyc(1'b1, 4'h0, "disable_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
